// File: rtl/bus_controller_pkg.sv
// bus_controller_pkg: shared region/state enums and region boundary constants
package bus_controller_pkg;
  typedef enum logic [1:0] {RGN_RAM, RGN_ROM, RGN_IO} region_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_e;
  localparam logic [15:0] IO_BASE  = 16'h8000;
  localparam logic [15:0] ROM_BASE = 16'hC000;
endpackage

// File: rtl/bus_controller_if.sv
// bus_controller_if: CPU-side and memory-side signals of the bus controller
interface bus_controller_if;
  logic        cpu_req;
  logic [15:0] address;
  logic        read_write;
  logic [7:0]  data_write;
  logic [7:0]  data_read;
  logic        ready;
  logic        bus_error;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        ram_en;
  logic        rom_en;
  logic        io_en;
  logic        mem_we;
  logic [7:0]  ram_rdata;
  logic [7:0]  rom_rdata;
  logic [7:0]  io_rdata;
  modport slave (
    input  cpu_req, address, read_write, data_write, ram_rdata, rom_rdata, io_rdata,
    output data_read, ready, bus_error, mem_addr, mem_wdata, ram_en, rom_en, io_en, mem_we
  );
  modport master (
    output cpu_req, address, read_write, data_write, ram_rdata, rom_rdata, io_rdata,
    input  data_read, ready, bus_error, mem_addr, mem_wdata, ram_en, rom_en, io_en, mem_we
  );
endinterface

// File: rtl/bus_controller_addr_decoder.sv
// addr_decoder: maps a 16-bit CPU address onto its memory region
module addr_decoder
  import bus_controller_pkg::*;
(
  input  logic [15:0] addr_i,
  output region_e     region_o
);
  always_comb region_o = addr_i >= ROM_BASE ? RGN_ROM : addr_i >= IO_BASE ? RGN_IO : RGN_RAM;
endmodule

// File: rtl/bus_controller.sv
// bus_controller: 6502-style bus cycle sequencer with per-region wait states
module bus_controller
  import bus_controller_pkg::*;
#(
  parameter int unsigned RAM_WAIT = 0,
  parameter int unsigned ROM_WAIT = 1,
  parameter int unsigned IO_WAIT  = 2
) (
  input logic             clk,
  input logic             reset_n,
  bus_controller_if.slave bus
);
  state_e      state_q;
  region_e     region_q, req_rgn;
  logic [2:0]  cnt_q, req_wait;
  logic        rd_q, ready_q, bus_error_q, mem_we_q, ram_en_q, rom_en_q, io_en_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q, data_read_q, rdata_sel;
  logic        accept, we_ok;
  addr_decoder u_dec (.addr_i(bus.address), .region_o(req_rgn));
  always_comb begin
    req_wait  = req_rgn == RGN_ROM ? 3'(ROM_WAIT) : req_rgn == RGN_IO ? 3'(IO_WAIT) : 3'(RAM_WAIT);
    accept    = state_q != ST_ACCESS && bus.cpu_req;
    rdata_sel = region_q == RGN_ROM ? bus.rom_rdata : region_q == RGN_IO ? bus.io_rdata : bus.ram_rdata;
    we_ok     = !rd_q && region_q != RGN_ROM;
  end
  // mem_we is registered one cycle ahead so it lands exactly on the counter==0 cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      region_q    <= RGN_RAM;
      cnt_q       <= '0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      data_read_q <= '0;
      ready_q     <= 1'b0;
      bus_error_q <= 1'b0;
      mem_we_q    <= 1'b0;
      ram_en_q    <= 1'b0;
      rom_en_q    <= 1'b0;
      io_en_q     <= 1'b0;
    end else if (accept) begin
      state_q     <= ST_ACCESS;
      region_q    <= req_rgn;
      rd_q        <= bus.read_write;
      addr_q      <= bus.address;
      wdata_q     <= bus.data_write;
      cnt_q       <= req_wait;
      ready_q     <= 1'b0;
      bus_error_q <= 1'b0;
      mem_we_q    <= req_wait == 3'd0 && !bus.read_write && req_rgn != RGN_ROM;
      ram_en_q    <= req_rgn == RGN_RAM;
      rom_en_q    <= req_rgn == RGN_ROM;
      io_en_q     <= req_rgn == RGN_IO;
    end else if (state_q == ST_ACCESS && cnt_q != 3'd0) begin
      cnt_q    <= cnt_q - 3'd1;
      mem_we_q <= cnt_q == 3'd1 && we_ok;
    end else if (state_q == ST_ACCESS) begin
      state_q     <= ST_RESP;
      ready_q     <= 1'b1;
      bus_error_q <= !rd_q && region_q == RGN_ROM;
      mem_we_q    <= 1'b0;
      ram_en_q    <= 1'b0;
      rom_en_q    <= 1'b0;
      io_en_q     <= 1'b0;
      if (rd_q) data_read_q <= rdata_sel;
    end else begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b0;
      bus_error_q <= 1'b0;
    end
  end
  assign bus.data_read = data_read_q;
  assign bus.ready     = ready_q;
  assign bus.bus_error = bus_error_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.ram_en    = ram_en_q;
  assign bus.rom_en    = rom_en_q;
  assign bus.io_en     = io_en_q;
endmodule
